// File: rtl/ram_1p_ctrl_pkg.sv
// ram_1p_ctrl_pkg: shared types and constants for the single-port RAM
// controller (sequencer + two-requester round-robin arbiter).
//   ctrl_state_e : controller FSM states (reset, fill, arbitrate)
//   owner_e      : which requester owns an in-flight read
//   NumReq       : number of requesters sharing the RAM port
package ram_1p_ctrl_pkg;

  typedef enum logic [1:0] {
    StReset = 2'd0,
    StInit  = 2'd1,
    StArb   = 2'd2
  } ctrl_state_e;

  typedef enum logic {
    OwnA = 1'b0,
    OwnB = 1'b1
  } owner_e;

  localparam int NumReq = 2;

endpackage

// File: rtl/ram_1p_ctrl_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter with a last-grant register.
// Grant decision is combinational; only the last-grant pointer is stored.
// After reset the pointer says B, so A wins the first tie.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en            : arbitration enable (no grants while low)
//   req[1:0]      : request vector, bit 0 = A, bit 1 = B
//   gnt[1:0]      : one-hot (or zero) grant vector, same bit order
module rr_arb2
  import ram_1p_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt
);

  owner_e last_grant;

  // Grant selection: A wins unless B also requests and A was served last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req[0] && (!req[1] || last_grant == OwnB)) begin
        gnt = 2'b01;
      end else if (req[1]) begin
        // Reached either when A is idle or when A was served last.
        gnt = 2'b10;
      end else begin
        gnt = 2'b00;
      end
    end else begin
      gnt = 2'b00;
    end
  end

  // Last-grant pointer, moves only when a grant is issued.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= OwnB;
    end else if (gnt[0]) begin
      last_grant <= OwnA;
    end else if (gnt[1]) begin
      last_grant <= OwnB;
    end else begin
      last_grant <= last_grant;
    end
  end

endmodule

// File: rtl/ram_1p_ctrl.sv
// ram_1p_ctrl: sequencer and round-robin arbiter in front of a single-port
// RAM with 1-cycle read latency. After reset it can fill every word with
// FillValue, then shares the RAM port between requesters A and B.
// Build option: define RAM1P_CTRL_FILL_EN to include the fill sequencer;
// without it the controller goes straight to arbitration after reset.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   a_req_i/a_we_i/a_addr_i/a_wdata_i : requester A command
//   a_gnt_o                       : A accepted this cycle
//   a_rvalid_o/a_rdata_o          : A read return (1 cycle after grant)
//   b_*                           : same set for requester B
//   ram_req_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i : RAM port
//   init_done_o                   : fill complete, arbitration active
module ram_1p_ctrl
  import ram_1p_ctrl_pkg::*;
#(
  parameter int unsigned       Depth       = 256,
  parameter int unsigned       Width       = 32,
  parameter string             MemInitFile = "",
  parameter logic [Width-1:0]  FillValue   = '0,
  parameter int unsigned       AddrW       = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  input  logic             a_we_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  output logic             a_gnt_o,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  input  logic             b_we_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  output logic             b_gnt_o,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  input  logic [Width-1:0] ram_rdata_i,
  output logic             init_done_o
);

`ifdef RAM1P_CTRL_FILL_EN
  localparam bit FillBuild = 1'b1;
`else
  localparam bit FillBuild = 1'b0;
`endif
  // A preload file supplies the contents, so the fill is skipped then.
  localparam bit FillOn = FillBuild && (MemInitFile == "");
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Depth - 1);

  ctrl_state_e state;
  logic [NumReq-1:0] gnt;
  logic [AddrW-1:0]  fill_addr;
  logic [AddrW-1:0]  addr_q;
  logic [Width-1:0]  wdata_q;
  logic              rd_valid;
  owner_e            rd_owner;

`ifdef RAM1P_CTRL_FILL_EN
  logic [AddrW-1:0] fill_cnt;
  assign fill_addr = fill_cnt;
`else
  assign fill_addr = '0;
`endif

  // Controller FSM with fill counter and registered init_done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= StReset;
      init_done_o <= 1'b0;
`ifdef RAM1P_CTRL_FILL_EN
      fill_cnt    <= '0;
`endif
    end else begin
      case (state)
        StReset: begin
          state       <= FillOn ? StInit : StArb;
          init_done_o <= !FillOn;
        end
        StInit: begin
`ifdef RAM1P_CTRL_FILL_EN
          if (fill_cnt == LastAddr) begin
            state       <= StArb;
            init_done_o <= 1'b1;
          end else begin
            state       <= StInit;
            init_done_o <= 1'b0;
            fill_cnt    <= fill_cnt + AddrW'(1);
          end
`else
          state       <= StArb;
          init_done_o <= 1'b1;
`endif
        end
        StArb: begin
          state       <= StArb;
          init_done_o <= 1'b1;
        end
        default: begin
          state       <= StReset;
          init_done_o <= 1'b0;
        end
      endcase
    end
  end

  rr_arb2 u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en     (state == StArb),
    .req    ({b_req_i, a_req_i}),
    .gnt    (gnt)
  );

  assign a_gnt_o = gnt[0];
  assign b_gnt_o = gnt[1];

  // RAM port mux: fill writes, winning requester, or idle with held addr/data.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = addr_q;
    ram_wdata_o = wdata_q;
    case (state)
      StInit: begin
        ram_req_o   = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = fill_addr;
        ram_wdata_o = FillValue;
      end
      StArb: begin
        if (gnt[0]) begin
          ram_req_o   = 1'b1;
          ram_we_o    = a_we_i;
          ram_addr_o  = a_addr_i;
          ram_wdata_o = a_wdata_i;
        end else if (gnt[1]) begin
          ram_req_o   = 1'b1;
          ram_we_o    = b_we_i;
          ram_addr_o  = b_addr_i;
          ram_wdata_o = b_wdata_i;
        end else begin
          ram_req_o   = 1'b0;
          ram_we_o    = 1'b0;
        end
      end
      default: begin
        ram_req_o = 1'b0;
        ram_we_o  = 1'b0;
      end
    endcase
  end

  // Hold registers for idle addr/data and the read-return owner tag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_valid <= 1'b0;
      rd_owner <= OwnA;
    end else begin
      if (ram_req_o) begin
        addr_q  <= ram_addr_o;
        wdata_q <= ram_wdata_o;
      end else begin
        addr_q  <= addr_q;
        wdata_q <= wdata_q;
      end
      rd_valid <= (gnt[0] && !a_we_i) || (gnt[1] && !b_we_i);
      rd_owner <= gnt[1] ? OwnB : OwnA;
    end
  end

  assign a_rvalid_o = rd_valid && (rd_owner == OwnA);
  assign b_rvalid_o = rd_valid && (rd_owner == OwnB);
  // Both requesters see the RAM output; only the owner's rvalid qualifies it.
  assign a_rdata_o  = ram_rdata_i;
  assign b_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_ram_1p_ctrl.sv
// tb_ram_1p_ctrl: directed, table-driven bench for ram_1p_ctrl with a small
// behavioural RAM (1-cycle read latency). A second instance with a preload
// file name must never touch its RAM and must finish init immediately.
module tb_ram_1p_ctrl;

  localparam int Depth = 8;
  localparam int Width = 32;
  localparam int AW    = 3;
  localparam logic [31:0] K = 32'hA5A5A5A5;
`ifdef RAM1P_CTRL_FILL_EN
  localparam int NFill = Depth;
`else
  localparam int NFill = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [31:0] a_wdata = '0, b_wdata = '0;
  logic a_gnt, a_rv, b_gnt, b_rv, ram_req, ram_we, init_done;
  logic [31:0] a_rdata, b_rdata, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic [AW-1:0] ram_addr;
  logic [31:0] mem [Depth];

  logic d2_a_gnt, d2_a_rv, d2_b_gnt, d2_b_rv, d2_ram_req, d2_ram_we, d2_init_done;
  logic [31:0] d2_a_rdata, d2_b_rdata, d2_ram_wdata;
  logic [AW-1:0] d2_ram_addr;
  int d2_accesses = 0;

  int errors = 0;
  int checks = 0;

  ram_1p_ctrl #(.Depth(Depth), .Width(Width), .MemInitFile(""), .FillValue(K)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rv), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_gnt_o(b_gnt), .b_rvalid_o(b_rv), .b_rdata_o(b_rdata),
    .ram_req_o(ram_req), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .init_done_o(init_done)
  );

  ram_1p_ctrl #(.Depth(Depth), .Width(Width), .MemInitFile("x.hex"), .FillValue(K)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(1'b0), .a_we_i(1'b0), .a_addr_i(3'd0), .a_wdata_i(32'd0),
    .a_gnt_o(d2_a_gnt), .a_rvalid_o(d2_a_rv), .a_rdata_o(d2_a_rdata),
    .b_req_i(1'b0), .b_we_i(1'b0), .b_addr_i(3'd0), .b_wdata_i(32'd0),
    .b_gnt_o(d2_b_gnt), .b_rvalid_o(d2_b_rv), .b_rdata_o(d2_b_rdata),
    .ram_req_o(d2_ram_req), .ram_we_o(d2_ram_we), .ram_addr_o(d2_ram_addr),
    .ram_wdata_o(d2_ram_wdata), .ram_rdata_i(32'd0), .init_done_o(d2_init_done)
  );

  // Behavioural single-port RAM, registered read data.
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(posedge clk) begin
    if (rst_n && d2_ram_req) d2_accesses <= d2_accesses + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
    chk({tag, "_a_rv"}, a_rv, 0);
    chk({tag, "_b_rv"}, b_rv, 0);
    chk({tag, "_ram_req"}, ram_req, 0);
    chk({tag, "_ram_we"}, ram_we, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_init_done"}, init_done, 0);
  endtask

  // Release reset at a falling edge and follow the fill; abort_at >= 0
  // reasserts reset right after the fill write to that address.
  task automatic release_fill(input int abort_at);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_init_done", init_done, 0);
    chk("rel_ram_req", ram_req, 0);
    chk("rel_a_gnt", a_gnt, 0);
    chk("rel_b_gnt", b_gnt, 0);
    chk("rel_a_rv", a_rv, 0);
    chk("rel_b_rv", b_rv, 0);
    chk("d2_init_done_c0", d2_init_done, 0);
    for (int c = 1; c <= NFill + 1; c++) begin
      @(negedge clk);
      chk("d2_init_done_c1", d2_init_done, 1);
      if (c <= NFill) begin
        chk($sformatf("fill%0d_req", c - 1), ram_req, 1);
        chk($sformatf("fill%0d_we", c - 1), ram_we, 1);
        chk($sformatf("fill%0d_addr", c - 1), ram_addr, c - 1);
        chk($sformatf("fill%0d_wdata", c - 1), ram_wdata, K);
        chk($sformatf("fill%0d_init_done", c - 1), init_done, 0);
        chk($sformatf("fill%0d_a_gnt", c - 1), a_gnt, 0);
        chk($sformatf("fill%0d_b_gnt", c - 1), b_gnt, 0);
        if (c - 1 == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk_idle_reset("midfill_rst");
          return;
        end
      end else begin
        chk("init_done_rise", init_done, 1);
      end
    end
  endtask

  typedef struct {
    logic a_req; logic a_we; logic [AW-1:0] a_addr; logic [31:0] a_wdata;
    logic b_req; logic b_we; logic [AW-1:0] b_addr; logic [31:0] b_wdata;
    logic e_a_gnt; logic e_b_gnt; logic e_req; logic e_we;
    logic [AW-1:0] e_addr; logic [31:0] e_wdata;
    logic e_a_rv; logic e_b_rv; logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [17];

  initial begin
    // Contention reads, holds, write-then-read, repeated wins, tie on writes.
    vecs[0]  = '{1'b1,1'b0,3'd3,32'hAA, 1'b1,1'b0,3'd5,32'hBB, 1'b1,1'b0, 1'b1,1'b0,3'd3,32'hAA, 1'b0,1'b0,32'h0};
    vecs[1]  = '{1'b1,1'b0,3'd3,32'hAA, 1'b1,1'b0,3'd5,32'hBB, 1'b0,1'b1, 1'b1,1'b0,3'd5,32'hBB, 1'b1,1'b0,K};
    vecs[2]  = '{1'b1,1'b0,3'd3,32'hAA, 1'b1,1'b0,3'd5,32'hBB, 1'b1,1'b0, 1'b1,1'b0,3'd3,32'hAA, 1'b0,1'b1,K};
    vecs[3]  = '{1'b1,1'b0,3'd3,32'hAA, 1'b1,1'b0,3'd5,32'hBB, 1'b0,1'b1, 1'b1,1'b0,3'd5,32'hBB, 1'b1,1'b0,K};
    vecs[4]  = '{1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0, 1'b0,1'b0,3'd5,32'hBB, 1'b0,1'b1,K};
    vecs[5]  = '{1'b1,1'b1,3'd2,32'h1234, 1'b0,1'b0,3'd0,32'h0, 1'b1,1'b0, 1'b1,1'b1,3'd2,32'h1234, 1'b0,1'b0,32'h0};
    vecs[6]  = '{1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0,3'd2,32'hCC, 1'b0,1'b1, 1'b1,1'b0,3'd2,32'hCC, 1'b0,1'b0,32'h0};
    vecs[7]  = '{1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0, 1'b0,1'b0,3'd2,32'hCC, 1'b0,1'b1,32'h1234};
    vecs[8]  = '{1'b1,1'b0,3'd2,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0, 1'b1,1'b0,3'd2,32'h0,  1'b0,1'b0,32'h0};
    vecs[9]  = '{1'b1,1'b0,3'd7,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0, 1'b1,1'b0,3'd7,32'h0,  1'b1,1'b0,32'h1234};
    vecs[10] = '{1'b1,1'b0,3'd7,32'h0,  1'b1,1'b0,3'd0,32'hDD, 1'b0,1'b1, 1'b1,1'b0,3'd0,32'hDD, 1'b1,1'b0,K};
    vecs[11] = '{1'b1,1'b0,3'd7,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0, 1'b1,1'b0,3'd7,32'h0,  1'b0,1'b1,K};
    vecs[12] = '{1'b1,1'b1,3'd1,32'h11, 1'b1,1'b1,3'd6,32'h66, 1'b0,1'b1, 1'b1,1'b1,3'd6,32'h66, 1'b1,1'b0,K};
    vecs[13] = '{1'b1,1'b1,3'd1,32'h11, 1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0, 1'b1,1'b1,3'd1,32'h11, 1'b0,1'b0,32'h0};
    vecs[14] = '{1'b1,1'b0,3'd1,32'hEE, 1'b1,1'b0,3'd6,32'hFF, 1'b0,1'b1, 1'b1,1'b0,3'd6,32'hFF, 1'b0,1'b0,32'h0};
    vecs[15] = '{1'b1,1'b0,3'd1,32'hEE, 1'b0,1'b0,3'd0,32'h0,  1'b1,1'b0, 1'b1,1'b0,3'd1,32'hEE, 1'b0,1'b1,32'h66};
    vecs[16] = '{1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0,3'd0,32'h0,  1'b0,1'b0, 1'b0,1'b0,3'd1,32'hEE, 1'b1,1'b0,32'h11};

    // Without a fill the RAM model starts as if preloaded with K.
    for (int i = 0; i < Depth; i++) mem[i] = K;

    repeat (3) @(negedge clk);
    #1;
    chk_idle_reset("reset");

    // Both requesters active through reset and fill; a first fill is aborted.
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd7;
    release_fill(3);
    rst_n = 1'b0;
    release_fill(-1);

    // First ARB cycle: A wins the tie, then B, then both reads return K.
    chk("arb0_a_gnt", a_gnt, 1);
    chk("arb0_b_gnt", b_gnt, 0);
    chk("arb0_ram_req", ram_req, 1);
    chk("arb0_ram_we", ram_we, 0);
    chk("arb0_ram_addr", ram_addr, 0);
    @(posedge clk); #1;
    a_req = 1'b0;
    @(negedge clk);
    chk("arb1_b_gnt", b_gnt, 1);
    chk("arb1_ram_addr", ram_addr, 7);
    chk("arb1_a_rv", a_rv, 1);
    chk("arb1_a_rdata", a_rdata, K);
    chk("arb1_b_rv", b_rv, 0);
    @(posedge clk); #1;
    b_req = 1'b0;
    @(negedge clk);
    chk("arb2_b_rv", b_rv, 1);
    chk("arb2_b_rdata", b_rdata, K);
    chk("arb2_a_rv", a_rv, 0);
    chk("arb2_ram_req", ram_req, 0);
    chk("arb2_ram_addr_hold", ram_addr, 7);

    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1;
      a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr; a_wdata = vecs[i].a_wdata;
      b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr; b_wdata = vecs[i].b_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_a_gnt", i), a_gnt, vecs[i].e_a_gnt);
      chk($sformatf("v%0d_b_gnt", i), b_gnt, vecs[i].e_b_gnt);
      chk($sformatf("v%0d_ram_req", i), ram_req, vecs[i].e_req);
      chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_a_rv", i), a_rv, vecs[i].e_a_rv);
      chk($sformatf("v%0d_b_rv", i), b_rv, vecs[i].e_b_rv);
      if (vecs[i].e_a_rv) chk($sformatf("v%0d_a_rdata", i), a_rdata, vecs[i].e_rdata);
      if (vecs[i].e_b_rv) chk($sformatf("v%0d_b_rdata", i), b_rdata, vecs[i].e_rdata);
      chk($sformatf("v%0d_init_done", i), init_done, 1);
    end

    // Reset while a read is in flight: its rvalid must never appear.
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd4;
    b_req = 1'b0;
    @(negedge clk);
    chk("midread_a_gnt", a_gnt, 1);
    rst_n = 1'b0;
    #1;
    chk_idle_reset("midread_rst");
    a_req = 1'b0;
    @(negedge clk);
    chk("midread_a_rv_lost", a_rv, 0);
    release_fill(-1);

    chk("d2_no_ram_access", d2_accesses, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_1p_ctrl.md
Name: ram_1p_ctrl

Overview:
- Sequencer and two-port arbiter in front of a single-port RAM (ram_1p-class macro, 1-cycle read latency).
- After reset, optionally fills every word with a constant; then shares the one RAM port between requesters A and B, round-robin.
- Sits between the RAM instance and its two clients; the RAM's own preload parameter is passed down as MemInitFile.

Parameters:
- Depth, 256, number of RAM words (power of two, >=2).
- Width, 32, data width in bits.
- MemInitFile, "", preload file name; non-empty means contents come from the file and the fill is skipped.
- FillValue, '0, word written during fill (Width bits).
- AddrW, $clog2(Depth), derived address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- a_req_i  in  1  requester A access request.
- a_we_i  in  1  A write enable (1 = write).
- a_addr_i  in  AddrW  A address.
- a_wdata_i  in  Width  A write data.
- a_gnt_o  out  1  A request accepted this cycle.
- a_rvalid_o  out  1  A read data valid.
- a_rdata_o  out  Width  A read data.
- b_req_i / b_we_i / b_addr_i / b_wdata_i / b_gnt_o / b_rvalid_o / b_rdata_o: same as A, for requester B.
- ram_req_o  out  1  RAM access strobe.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  AddrW  RAM address.
- ram_wdata_o  out  Width  RAM write data.
- ram_rdata_i  in  Width  RAM read data, valid 1 cycle after a read strobe.
- init_done_o  out  1  fill complete; arbitration active.

Behaviour:
- Reset values (async, rst_ni low): all *_gnt_o, *_rvalid_o, ram_req_o, ram_we_o and init_done_o = 0; ram_addr_o = 0; ram_wdata_o = 0; state = RESET; fill counter = 0; last_grant = B, so A wins the first tie.
- States:
  - RESET: first cycle after reset release. Goes to INIT if fill is enabled (see Optional Feature) and MemInitFile == ""; otherwise goes to ARB.
  - INIT: one write per cycle: ram_req_o = 1, ram_we_o = 1, ram_addr_o = counter, ram_wdata_o = FillValue. Counter runs 0..Depth-1. On the cycle the write to Depth-1 issues, the next state is ARB. Fill takes exactly Depth cycles. Counter wrap is not used.
  - ARB: init_done_o = 1 from the first ARB cycle onward. ARB is terminal until the next reset.
- Arbitration is combinational within the cycle:
  - Grant A if a_req_i and (!b_req_i or last_grant == B); grant B if b_req_i and (!a_req_i or last_grant == A).
  - At most one grant per cycle. last_grant updates only on a grant.
  - The winner's we/addr/wdata drive the RAM port in the same cycle, with ram_req_o = 1.
  - In RESET and INIT, both gnt_o = 0 regardless of req.
- Read return:
  - A registered owner tag records the granted requester and that the access was a read.
  - Next cycle, that requester's rvalid_o = 1 and its rdata_o = ram_rdata_i.
  - Writes produce no rvalid.
  - Back-to-back grants pipeline fully: 1 access per cycle, fixed 1-cycle read latency.
- Requesters hold req/we/addr/wdata stable until granted. Dropping req before a grant is allowed and has no effect.
- rdata_o of the non-owner is don't-care, driven with ram_rdata_i.
- Reset mid-INIT or mid-read: everything returns to the reset values; a pending rvalid is discarded; the fill restarts from address 0.
- When idle in ARB: ram_req_o = 0; ram_addr_o and ram_wdata_o hold their last values.

Optional Feature:
- Macro RAM1P_CTRL_FILL_EN.
- Defined: INIT state and fill counter are present; the fill runs when MemInitFile == "".
- Undefined: INIT logic and counter are removed. RESET always goes to ARB, so init_done_o rises 1 cycle after reset release. FillValue is ignored.

Decomposition:
- Package ram_1p_ctrl_pkg holds:
  - typedef enum logic [1:0] {StReset, StInit, StArb} ctrl_state_e;
  - typedef enum logic {OwnA, OwnB} owner_e;
  - localparam NumReq = 2.
- One natural sub-module: rr_arb2 (two-input round-robin arbiter with last_grant register, on clk_i/rst_ni).
- Top level holds the FSM, fill counter, mux and read-return tag.

Test Plan:
- Fill enabled, Depth=8, MemInitFile="", FillValue=32'hA5A5A5A5 -> RAM sees 8 consecutive writes, addr 0..7; init_done_o rises the cycle after addr 7; reads of addr 0 and addr 7 return A5A5A5A5.
- MemInitFile="x.hex", fill enabled -> no RAM writes; init_done_o = 1 one cycle after reset release.
- A and B both request continuously (reads, addr 3 / addr 5) -> grants alternate A,B,A,B starting with A; each rvalid arrives exactly 1 cycle after its grant with the correct rdata.
- A writes 32'h1234 to addr 2; next cycle B reads addr 2 -> b_rvalid_o one cycle later with rdata 32'h1234; a_rvalid_o never asserts.
- Requests during INIT (cycle 3 of 8) -> no grants until init_done_o; the first grant is in the first ARB cycle.
- rst_ni pulsed low during cycle 4 of fill and during a pending read -> all outputs zero immediately; the pending rvalid is lost; the fill restarts at addr 0.
